// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : int_ctrl
// Brief   : Edge-triggered, fixed-priority interrupt controller with a bus-
//           visible pending/enable/status/EOI register set.
// Revision: 1.0 - initial release
// ============================================================================
module int_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               imask,
  input  logic               int_ack,
  output logic               hwint,
  output logic [4:0]         int_id,
  input  logic               en,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] bus_clr;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] enable_nxt;
  logic [NUM_IRQ-1:0] candidate;
  logic [4:0]         win_idx;
  logic               wr_en;
  logic               rd_en;
  logic               eoi;
  logic               keep_req;
  logic [31:0]        pending_ext;
  logic [31:0]        enable_ext;
  logic [31:0]        rd_data;
  logic               unused_data_bits;

  assign unused_data_bits = ^data_in;

  always_comb begin
    wr_en    = en & wr;
    rd_en    = en & rd;
    eoi      = wr_en && (addr == ADDR_EOI);
    irq_edge = irq & ~irq_prev;

    id_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int_id == i[4:0]) id_onehot[i] = 1'b1;
    end

    bus_clr = '0;
    if (wr_en && (addr == ADDR_PENDING)) bus_clr = data_in[NUM_IRQ-1:0];
    ack_clr = (state == REQUEST && int_ack) ? id_onehot : '0;

    // Edges are ORed in last so a new edge beats any clear in the same cycle.
    pending_nxt = (pending & ~(bus_clr | ack_clr)) | irq_edge;
    enable_nxt  = (wr_en && (addr == ADDR_ENABLE)) ? data_in[NUM_IRQ-1:0] : enable;

    candidate = pending & enable;
    win_idx   = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (candidate[i]) win_idx = i[4:0];
    end

    // A request survives only if its source is still pending and enabled after
    // this cycle's bus writes and the global mask is open.
    keep_req = ~imask && |(pending_nxt & enable_nxt & id_onehot);

    pending_ext = '0;
    pending_ext[NUM_IRQ-1:0] = pending;
    enable_ext = '0;
    enable_ext[NUM_IRQ-1:0] = enable;

    case (addr)
      ADDR_PENDING: rd_data = pending_ext;
      ADDR_ENABLE:  rd_data = enable_ext;
      ADDR_STATUS:  rd_data = {(state == SERVICE), 26'd0, int_id};
      default:      rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hwint    <= 1'b0;
      int_id   <= 5'd0;
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '0;
      data_out <= 32'd0;
    end else begin
      irq_prev <= irq;
      pending  <= pending_nxt;
      enable   <= enable_nxt;
      if (rd_en) data_out <= rd_data;

      case (state)
        IDLE: begin
          if (|candidate && !imask) begin
            state  <= REQUEST;
            hwint  <= 1'b1;
            int_id <= win_idx;
          end
        end
        REQUEST: begin
          if (int_ack) begin
            state <= SERVICE;
            hwint <= 1'b0;
          end else if (!keep_req) begin
            state <= IDLE;
            hwint <= 1'b0;
          end
        end
        SERVICE: begin
          hwint <= 1'b0;
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          hwint <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_int_ctrl
// Brief   : Directed self-checking bench for int_ctrl (NUM_IRQ = 8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        imask;
  logic        int_ack;
  logic        hwint;
  logic [4:0]  int_id;
  logic        en;
  logic        rd;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;

  int_ctrl #(.NUM_IRQ(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .imask    (imask),
    .int_ack  (int_ack),
    .hwint    (hwint),
    .int_id   (int_id),
    .en       (en),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    tick();
    en = 1'b0; wr = 1'b0; data_in = 32'd0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    en = 1'b1; rd = 1'b1; addr = a;
    tick();
    en = 1'b0; rd = 1'b0;
    check(tag, data_out, exp);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; imask = 1'b0; int_ack = 1'b0;
    en = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; data_in = 32'd0;
    #2;
    check("rst_hwint", {31'd0, hwint}, 32'd0);
    check("rst_int_id", {27'd0, int_id}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    tick(); tick();
    rst = 1'b0;
    bus_rd(2'd1, "rst_enable", 32'h0);
    bus_rd(2'd0, "rst_pending", 32'h0);

    // Single source: enable bit 2, raise irq[2]
    bus_wr(2'd1, 32'h04);
    irq = 8'h04;
    tick();
    check("lat_hwint_k", {31'd0, hwint}, 32'd0);
    tick();
    check("lat_hwint_k1", {31'd0, hwint}, 32'd1);
    check("single_id", {27'd0, int_id}, 32'd2);
    ack();
    check("ack_hwint", {31'd0, hwint}, 32'd0);
    bus_rd(2'd0, "ack_pending", 32'h00);
    bus_rd(2'd2, "svc_status", 32'h8000_0002);
    bus_wr(2'd3, 32'h0);
    tick();
    check("eoi_idle_hwint", {31'd0, hwint}, 32'd0);
    irq = 8'h00;
    tick();

    // Priority: irq[5] and irq[1] together
    bus_wr(2'd1, 32'hFF);
    irq = 8'h22;
    tick(); tick();
    check("prio_hwint", {31'd0, hwint}, 32'd1);
    check("prio_id1", {27'd0, int_id}, 32'd1);
    ack();
    bus_rd(2'd0, "prio_pending", 32'h20);
    check("prio_svc_hwint", {31'd0, hwint}, 32'd0);
    bus_wr(2'd3, 32'h0);
    tick();
    check("prio_rearm_hwint", {31'd0, hwint}, 32'd1);
    check("prio_id5", {27'd0, int_id}, 32'd5);
    ack();
    bus_wr(2'd3, 32'h0);
    irq = 8'h00;
    tick();
    bus_rd(2'd0, "prio_pending_end", 32'h00);

    // Global mask holds off the request
    imask = 1'b1;
    bus_wr(2'd1, 32'h08);
    irq = 8'h08;
    tick(); tick(); tick();
    check("mask_hwint", {31'd0, hwint}, 32'd0);
    bus_rd(2'd0, "mask_pending", 32'h08);
    imask = 1'b0;
    tick();
    check("unmask_hwint", {31'd0, hwint}, 32'd1);
    check("unmask_id", {27'd0, int_id}, 32'd3);
    bus_wr(2'd3, 32'h0);
    check("eoi_in_req_hwint", {31'd0, hwint}, 32'd1);
    ack();
    bus_wr(2'd3, 32'h0);
    irq = 8'h00;
    tick();

    // Bus clear of the requested source withdraws the request
    bus_wr(2'd1, 32'h10);
    irq = 8'h10;
    tick(); tick();
    check("w1c_req_hwint", {31'd0, hwint}, 32'd1);
    check("w1c_req_id", {27'd0, int_id}, 32'd4);
    bus_wr(2'd0, 32'h10);
    check("w1c_abort_hwint", {31'd0, hwint}, 32'd0);
    bus_rd(2'd2, "w1c_status", 32'h0000_0004);
    tick();
    check("w1c_stay_idle", {31'd0, hwint}, 32'd0);
    irq = 8'h00;
    tick();

    // Edge and W1C on the same bit: set wins
    bus_wr(2'd1, 32'h00);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    tick();
    irq = 8'h01;
    bus_wr(2'd0, 32'h01);
    bus_rd(2'd0, "set_beats_clr", 32'h01);
    bus_wr(2'd0, 32'h01);
    bus_rd(2'd0, "w1c_alone", 32'h00);
    irq = 8'h00;
    tick();

    // Asynchronous reset during SERVICE
    bus_wr(2'd1, 32'h40);
    irq = 8'h40;
    tick(); tick();
    check("svc6_hwint", {31'd0, hwint}, 32'd1);
    ack();
    bus_rd(2'd2, "svc6_status", 32'h8000_0006);
    #2;
    rst = 1'b1;
    #1;
    check("async_hwint", {31'd0, hwint}, 32'd0);
    check("async_int_id", {27'd0, int_id}, 32'd0);
    check("async_data_out", data_out, 32'd0);
    tick();
    rst = 1'b0;
    bus_rd(2'd2, "post_rst_status", 32'h0);
    bus_rd(2'd1, "post_rst_enable", 32'h0);
    bus_rd(2'd0, "held_irq_edge", 32'h40);
    check("post_rst_hwint", {31'd0, hwint}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
